// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the 8-bit processor: opcodes, register indices, fetch FSM encoding.
// Used by the fetch unit, the ROM image builder and the datapath.
package proc_isa_pkg;

    localparam logic [3:0] OP_JC   = 4'd0;
    localparam logic [3:0] OP_JMP  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_MVI  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SC   = 4'd9;
    localparam logic [3:0] OP_CC   = 4'd10;
    localparam logic [3:0] OP_PUSH = 4'd11;
    localparam logic [3:0] OP_POP  = 4'd12;
    localparam logic [3:0] OP_IN   = 4'd13;
    localparam logic [3:0] OP_OUT  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    localparam logic [1:0] RA = 2'd0;
    localparam logic [1:0] RB = 2'd1;
    localparam logic [1:0] RC = 2'd2;
    localparam logic [1:0] RD = 2'd3;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Unprogrammed ROM bytes read as all-ones, which is a NOP.
    localparam logic [7:0] IR_RESET = 8'hFF;

    function automatic logic [15:0] opcode_onehot(input logic [3:0] op);
        return 16'h0001 << op;
    endfunction

endpackage

// File: rtl/isa_decode.sv
// Combinational opcode decoder: one-hot opcode plus the control-flow flags
// consumed by the next-PC mux.
module isa_decode
    import proc_isa_pkg::*;
(
    input  logic [3:0]  opcode,
    output logic [15:0] op_onehot,
    output logic        is_branch,
    output logic        is_jump
);

    assign op_onehot = opcode_onehot(opcode);
    assign is_branch = (opcode == OP_JC);
    assign is_jump   = (opcode == OP_JMP);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC and IR ownership, FETCH/ISSUE/WAIT sequencing,
// and JMP/JC resolution against the datapath carry and RA.
module instr_fetch_unit
    import proc_isa_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              carry_in,
    input  logic [3:0]        ra_in,
    input  logic              exec_busy,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        imm,
    output logic [15:0]       op_onehot
);

    logic [1:0]        state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       dec_onehot;
    logic              is_branch;
    logic              is_jump;
    logic [7:0]        jmp_target;

    isa_decode u_isa_decode (
        .opcode    (ir_q[7:4]),
        .op_onehot (dec_onehot),
        .is_branch (is_branch),
        .is_jump   (is_jump)
    );

    assign jmp_target = {ir_q[3:0], ra_in};

    // The PC commits once in ISSUE, so the following FETCH already uses the resolved target.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        case (state_q)
            ST_FETCH: begin
                ir_d    = rom_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (is_jump) begin
                    pc_d = ADDR_W'(jmp_target);
                end else if (is_branch && carry_in) begin
                    pc_d = pc_q + ADDR_W'(ir_q[3:0]);
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                end
                state_d = exec_busy ? ST_WAIT : ST_FETCH;
            end
            ST_WAIT: begin
                if (!exec_busy) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            ir_q    <= IR_RESET;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == ST_ISSUE);
    assign opcode      = ir_q[7:4];
    assign rd          = ir_q[3:2];
    assign rs          = ir_q[1:0];
    assign imm         = ir_q[3:0];
    assign op_onehot   = instr_valid ? dec_onehot : 16'h0000;

endmodule
